// File: rtl/sram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter_if
// Bundles the requester side and the SRAM_Controller side of the shared
// SRAM port.
//   req_i / addr_i / wdata_i / we_n_i : per-requester access requests
//                                       (requester k in slice k)
//   gnt_o / rvalid_o / busy_o         : registered grant, read-data-valid
//                                       strobes, busy flag
//   SRAM_address / SRAM_write_data / SRAM_we_n : muxed port to SRAM_Controller
//   SRAM_read_data                    : shared read bus from SRAM_Controller
// Modports: master = requesters, slave = arbiter, ctrl = SRAM_Controller.
// ---------------------------------------------------------------------------
interface sram_access_arbiter_if;
    logic [3:0]  req_i;
    logic [71:0] addr_i;
    logic [63:0] wdata_i;
    logic [3:0]  we_n_i;
    logic [3:0]  gnt_o;
    logic [3:0]  rvalid_o;
    logic        busy_o;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    modport master (
        output req_i, addr_i, wdata_i, we_n_i,
        input  gnt_o, rvalid_o, busy_o, SRAM_read_data
    );

    modport slave (
        input  req_i, addr_i, wdata_i, we_n_i,
        output gnt_o, rvalid_o, busy_o,
        output SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport ctrl (
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        output SRAM_read_data
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
// Shares the single SRAM_Controller port among UART (0), M1 (1), M3 (2) and
// VGA (3). VGA has absolute priority; 0-2 share round-robin with a burst
// limit. The SRAM port is muxed from the registered grant, and each read is
// tagged so rvalid_o[k] pulses READ_LATENCY cycles after requester k's read.
// Ports:
//   CLOCK_50_I : 50 MHz clock
//   resetn     : asynchronous active-low reset
//   bus        : sram_access_arbiter_if.slave (requests, grant, SRAM port)
// ---------------------------------------------------------------------------
module sram_access_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 16
) (
    input  logic                        CLOCK_50_I,
    input  logic                        resetn,
    sram_access_arbiter_if.slave        bus
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_ARB_IDLE = 1'b0,
        S_ARB_OWN  = 1'b1
    } arb_state_t;

    arb_state_t          state_r, state_s;
    logic [3:0]          gnt_r, gnt_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [1:0]          ptr_r, ptr_s;
    logic                busy_r;
    logic [3:0]          rv_pipe_r [READ_LATENCY];
    logic                own_req_s;
    logic                burst_hit_s;
    logic [2:0]          others_s;
    logic [17:0]         sram_addr_s;
    logic [15:0]         sram_wdata_s;
    logic                sram_we_n_s;
    logic [3:0]          push_s;

    // Round-robin pick among requesters 0-2, searching from pointer p.
    function automatic logic [3:0] rr_pick(input logic [2:0] m, input logic [1:0] p);
        logic [3:0] r;
        r = 4'b0000;
        case (p)
            2'd1: begin
                if (m[1])      r = 4'b0010;
                else if (m[2]) r = 4'b0100;
                else if (m[0]) r = 4'b0001;
                else           r = 4'b0000;
            end
            2'd2: begin
                if (m[2])      r = 4'b0100;
                else if (m[0]) r = 4'b0001;
                else if (m[1]) r = 4'b0010;
                else           r = 4'b0000;
            end
            default: begin
                if (m[0])      r = 4'b0001;
                else if (m[1]) r = 4'b0010;
                else if (m[2]) r = 4'b0100;
                else           r = 4'b0000;
            end
        endcase
        return r;
    endfunction

    // Next grant, state, burst count and round-robin pointer.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        own_req_s   = |(gnt_r & bus.req_i);
        others_s    = bus.req_i[2:0] & ~gnt_r[2:0];
        burst_hit_s = (cnt_r >= CW'(MAX_BURST - 1));
        case (state_r)
            S_ARB_IDLE: begin
                if (|bus.req_i) begin
                    gnt_s = bus.req_i[3] ? 4'b1000 : rr_pick(bus.req_i[2:0], ptr_r);
                end else begin
                    gnt_s = 4'b0000;
                end
            end
            S_ARB_OWN: begin
                // VGA either keeps its grant or preempts any owner 0-2.
                if (bus.req_i[3]) begin
                    gnt_s = 4'b1000;
                end else if (!own_req_s) begin
                    gnt_s = rr_pick(bus.req_i[2:0], ptr_r);
                end else if (burst_hit_s && (|others_s)) begin
                    gnt_s = rr_pick(others_s, ptr_r);
                end else begin
                    gnt_s = gnt_r;
                end
            end
            default: begin
                gnt_s = 4'b0000;
            end
        endcase

        if (|gnt_s) begin
            state_s = S_ARB_OWN;
        end else begin
            state_s = S_ARB_IDLE;
        end

        // Counter restarts on any grant change and saturates at MAX_BURST.
        if (gnt_s != gnt_r) begin
            cnt_s = '0;
        end else if ((|gnt_r) && (cnt_r < CW'(MAX_BURST))) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end

        if (gnt_s != gnt_r) begin
            case (gnt_s)
                4'b0001: ptr_s = 2'd1;
                4'b0010: ptr_s = 2'd2;
                4'b0100: ptr_s = 2'd0;
                default: ptr_s = ptr_r;
            endcase
        end else begin
            ptr_s = ptr_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_ARB_IDLE;
            gnt_r   <= 4'b0000;
            cnt_r   <= '0;
            ptr_r   <= 2'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
            busy_r  <= |gnt_s;
        end
    end

    // SRAM port mux from the registered grant; a dropped request never writes.
    always_comb begin
        sram_addr_s  = 18'h00000;
        sram_wdata_s = 16'h0000;
        sram_we_n_s  = 1'b1;
        case (gnt_r)
            4'b0001: begin
                sram_addr_s  = bus.addr_i[17:0];
                sram_wdata_s = bus.wdata_i[15:0];
                sram_we_n_s  = bus.we_n_i[0] | ~bus.req_i[0];
            end
            4'b0010: begin
                sram_addr_s  = bus.addr_i[35:18];
                sram_wdata_s = bus.wdata_i[31:16];
                sram_we_n_s  = bus.we_n_i[1] | ~bus.req_i[1];
            end
            4'b0100: begin
                sram_addr_s  = bus.addr_i[53:36];
                sram_wdata_s = bus.wdata_i[47:32];
                sram_we_n_s  = bus.we_n_i[2] | ~bus.req_i[2];
            end
            4'b1000: begin
                sram_addr_s  = bus.addr_i[71:54];
                sram_wdata_s = bus.wdata_i[63:48];
                sram_we_n_s  = bus.we_n_i[3] | ~bus.req_i[3];
            end
            default: begin
                sram_addr_s  = 18'h00000;
                sram_wdata_s = 16'h0000;
                sram_we_n_s  = 1'b1;
            end
        endcase
        // Only a requested read by the current owner gets a valid tag.
        if (sram_we_n_s) begin
            push_s = gnt_r & bus.req_i;
        end else begin
            push_s = 4'b0000;
        end
    end

    // Read-tag delay line; grant changes never cancel tags already in flight.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rv_pipe_r[i] <= 4'b0000;
            end
        end else begin
            rv_pipe_r[0] <= push_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rv_pipe_r[i] <= rv_pipe_r[i-1];
            end
        end
    end

    assign bus.gnt_o           = gnt_r;
    assign bus.busy_o          = busy_r;
    assign bus.rvalid_o        = rv_pipe_r[READ_LATENCY-1];
    assign bus.SRAM_address    = sram_addr_s;
    assign bus.SRAM_write_data = sram_wdata_s;
    assign bus.SRAM_we_n       = sram_we_n_s;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_access_arbiter
// Directed, self-checking bench for sram_access_arbiter. Expected values are
// hand-derived cycle by cycle: reset, single read with rvalid latency, write
// path, round-robin with burst limit, VGA preemption, read tags across a
// handover, reset mid-traffic and simultaneous requests.
// ---------------------------------------------------------------------------
module tb_sram_access_arbiter;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    sram_access_arbiter_if bus_if ();

    sram_access_arbiter dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        bus_if.req_i          = 4'b0000;
        bus_if.we_n_i         = 4'b1111;
        bus_if.addr_i         = {18'h2A5A5, 18'h3F000, 18'h00100, 18'h00042};
        bus_if.wdata_i        = {16'h5555, 16'hABCD, 16'h1234, 16'hBEEF};
        bus_if.SRAM_read_data = 16'h0000;

        // Reset values
        #3;
        chk("rst_gnt",   {28'd0, bus_if.gnt_o},    32'h0);
        chk("rst_rv",    {28'd0, bus_if.rvalid_o}, 32'h0);
        chk("rst_busy",  {31'd0, bus_if.busy_o},   32'h0);
        chk("rst_we_n",  {31'd0, bus_if.SRAM_we_n}, 32'h1);
        chk("rst_addr",  {14'd0, bus_if.SRAM_address}, 32'h0);
        chk("rst_wdata", {16'd0, bus_if.SRAM_write_data}, 32'h0);
        tick();
        tick();
        resetn = 1'b1;

        // Single read by M1: three accesses, rvalid 2 cycles after each
        bus_if.req_i = 4'b0010;
        tick();
        chk("t1_gnt",  {28'd0, bus_if.gnt_o}, 32'h2);
        chk("t1_addr", {14'd0, bus_if.SRAM_address}, 32'h00100);
        chk("t1_we_n", {31'd0, bus_if.SRAM_we_n}, 32'h1);
        chk("t1_busy", {31'd0, bus_if.busy_o}, 32'h1);
        tick();
        chk("t1_rv0", {28'd0, bus_if.rvalid_o}, 32'h0);
        tick();
        chk("t1_rv1", {28'd0, bus_if.rvalid_o}, 32'h2);
        tick();
        chk("t1_rv2", {28'd0, bus_if.rvalid_o}, 32'h2);
        bus_if.req_i = 4'b0000;
        tick();
        chk("t1_rv3",    {28'd0, bus_if.rvalid_o}, 32'h2);
        chk("t1_gnt_off", {28'd0, bus_if.gnt_o}, 32'h0);
        tick();
        chk("t1_rv_end", {28'd0, bus_if.rvalid_o}, 32'h0);
        chk("t1_idle",   {31'd0, bus_if.busy_o}, 32'h0);

        // Write path by M3
        bus_if.we_n_i = 4'b1011;
        bus_if.req_i  = 4'b0100;
        tick();
        chk("t2_gnt",   {28'd0, bus_if.gnt_o}, 32'h4);
        chk("t2_we_n",  {31'd0, bus_if.SRAM_we_n}, 32'h0);
        chk("t2_wdata", {16'd0, bus_if.SRAM_write_data}, 32'hABCD);
        chk("t2_addr",  {14'd0, bus_if.SRAM_address}, 32'h3F000);
        tick();
        chk("t2_gnt2",  {28'd0, bus_if.gnt_o}, 32'h4);
        chk("t2_rv0",   {28'd0, bus_if.rvalid_o}, 32'h0);
        bus_if.req_i  = 4'b0000;
        bus_if.we_n_i = 4'b1111;
        tick();
        chk("t2_gnt_off", {28'd0, bus_if.gnt_o}, 32'h0);
        chk("t2_rv1",   {28'd0, bus_if.rvalid_o}, 32'h0);
        tick();
        chk("t2_rv2",   {28'd0, bus_if.rvalid_o}, 32'h0);

        // Round-robin with burst limit: 0,1,2 each 16 cycles, then 0 again
        bus_if.req_i = 4'b0111;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 16; i++) begin
                tick();
                chk($sformatf("t3_rr_g%0d_c%0d", g, i), {28'd0, bus_if.gnt_o}, 32'h1 << g);
            end
        end
        tick();
        chk("t3_rr_wrap", {28'd0, bus_if.gnt_o}, 32'h1);

        // VGA preemption of M1, held 40 cycles past the burst limit
        bus_if.req_i = 4'b0010;
        tick();
        chk("t4_m1", {28'd0, bus_if.gnt_o}, 32'h2);
        tick();
        tick();
        chk("t4_m1_mid", {28'd0, bus_if.gnt_o}, 32'h2);
        bus_if.req_i = 4'b1010;
        for (int i = 0; i < 56; i++) begin
            tick();
            chk($sformatf("t4_vga_c%0d", i), {28'd0, bus_if.gnt_o}, 32'h8);
            if (i == 0) begin
                chk("t4_vga_addr", {14'd0, bus_if.SRAM_address}, 32'h2A5A5);
            end
        end
        bus_if.req_i = 4'b0010;
        tick();
        chk("t4_m1_back", {28'd0, bus_if.gnt_o}, 32'h2);

        // M1 reads to its burst limit, grant passes to UART (writing)
        bus_if.req_i  = 4'b0011;
        bus_if.we_n_i = 4'b1110;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("t5_m1_c%0d", i), {28'd0, bus_if.gnt_o}, 32'h2);
        end
        tick();
        chk("t5_gnt_uart", {28'd0, bus_if.gnt_o}, 32'h1);
        chk("t5_we_n",     {31'd0, bus_if.SRAM_we_n}, 32'h0);
        chk("t5_rv_a",     {28'd0, bus_if.rvalid_o}, 32'h2);
        tick();
        chk("t5_rv_last",  {28'd0, bus_if.rvalid_o}, 32'h2);
        chk("t5_gnt_keep", {28'd0, bus_if.gnt_o}, 32'h1);
        tick();
        chk("t5_rv_wr0",   {28'd0, bus_if.rvalid_o}, 32'h0);
        bus_if.we_n_i = 4'b1111;
        tick();
        chk("t5_rv_wr1",   {28'd0, bus_if.rvalid_o}, 32'h0);

        // Reset with UART reads in flight
        resetn       = 1'b0;
        bus_if.req_i = 4'b0000;
        #1;
        chk("t6_gnt",  {28'd0, bus_if.gnt_o},    32'h0);
        chk("t6_rv",   {28'd0, bus_if.rvalid_o}, 32'h0);
        chk("t6_busy", {31'd0, bus_if.busy_o},   32'h0);
        chk("t6_we_n", {31'd0, bus_if.SRAM_we_n}, 32'h1);
        chk("t6_addr", {14'd0, bus_if.SRAM_address}, 32'h0);
        tick();
        chk("t6_rv_held", {28'd0, bus_if.rvalid_o}, 32'h0);
        bus_if.req_i = 4'b0100;
        tick();
        chk("t6_gnt_held", {28'd0, bus_if.gnt_o}, 32'h0);
        resetn = 1'b1;
        tick();
        chk("t6_first_edge", {28'd0, bus_if.gnt_o}, 32'h4);
        chk("t6_busy_on",    {31'd0, bus_if.busy_o}, 32'h1);

        // Simultaneous new requests: VGA wins
        bus_if.req_i = 4'b0000;
        tick();
        chk("t7_idle", {28'd0, bus_if.gnt_o}, 32'h0);
        bus_if.req_i = 4'b1111;
        tick();
        chk("t7_vga_first", {28'd0, bus_if.gnt_o}, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single SRAM_Controller port among four requesters: UART loader, milestone1 (CSC), milestone3 (IDCT), and VGA fetch.
- Replaces the hard-wired per-top_state address/we_n muxing with a registered grant.
- Routes write traffic and tags returning read data so each requester knows when SRAM_read_data belongs to it.
- Sits between the requesters and SRAM_Controller in the project top level.

Parameters:
- READ_LATENCY, 2: clock cycles from a read address being driven on SRAM_address to valid SRAM_read_data.
- MAX_BURST, 16: maximum consecutive granted cycles for requester 0-2 while another requester waits.
- NUM_REQ, 4: number of requesters; fixed at 4. Index 0 = UART, 1 = M1, 2 = M3, 3 = VGA.

Ports:
- CLOCK_50_I  in  1  50 MHz clock
- resetn  in  1  asynchronous active-low reset
- req_i  in  4  per-requester access request
- addr_i  in  72  four 18-bit addresses; requester k occupies bits [18k+17:18k]
- wdata_i  in  64  four 16-bit write words; requester k occupies bits [16k+15:16k]
- we_n_i  in  4  per-requester write enable, active low
- gnt_o  out  4  one-hot grant, registered
- rvalid_o  out  4  per-requester read-data-valid strobe
- SRAM_address  out  18  to SRAM_Controller
- SRAM_write_data  out  16  to SRAM_Controller
- SRAM_we_n  out  1  to SRAM_Controller
- SRAM_read_data  in  16  from SRAM_Controller; passed to requesters unmodified on a shared bus
- busy_o  out  1  high while any grant is active

Behaviour:
- Reset: CLOCK_50_I, resetn is asynchronous, active-low.
  - gnt_o = 0, rvalid_o = 0, busy_o = 0, state = S_ARB_IDLE.
  - Burst counter = 0; round-robin pointer = 0; rvalid pipeline flushed.
  - SRAM_address = 0, SRAM_write_data = 0, SRAM_we_n = 1.
- SRAM port muxing is combinational from registered gnt_o:
  - owner k: SRAM_address = addr_i[k], SRAM_write_data = wdata_i[k], SRAM_we_n = we_n_i[k].
  - no owner: SRAM_address = 0, SRAM_we_n = 1.
  - SRAM_we_n is forced to 1 whenever the owner's req_i is low, so a dropping requester never writes.
- FSM states:
  - S_ARB_IDLE: no grant. If any req_i is high, choose a winner; gnt_o for the winner rises on the next edge; go to S_ARB_OWN. Latency from req to gnt is 1 cycle.
  - S_ARB_OWN: owner k keeps the grant while req_i[k] = 1. Every owned cycle is one SRAM access.
    - Burst counter increments each owned cycle.
    - Owner drops req with no other request pending: gnt_o clears next edge; go to S_ARB_IDLE.
    - Owner drops req with another request pending: grant passes directly to the new winner next edge, with no idle cycle.
- Winner selection:
  - VGA (3) has absolute priority. If req_i[3] is high, VGA wins at the next decision point and preempts any owner 0-2 at the next edge.
  - Otherwise, round-robin among 0-2 starting at the pointer.
  - On each new grant to k in 0-2, the pointer becomes (k+1) mod 3.
- Burst limit:
  - When the counter reaches MAX_BURST for owner 0-2 while another requester in 0-2 is waiting, the grant rotates to that requester next edge.
  - The counter resets on every grant change.
  - The VGA owner is never burst-limited.
- Preempted requester: it sees gnt_o[k] fall. The access in that final cycle is not performed by the arbiter. The requester must hold addr/we_n and req until gnt returns.
- Read tagging:
  - Each owned cycle with SRAM_we_n = 1 pushes owner id plus a valid bit into a READ_LATENCY-deep shift register.
  - rvalid_o[k] pulses exactly READ_LATENCY cycles later.
  - Writes push an invalid entry.
  - A grant change never cancels in-flight tags; rvalid_o can fire for a requester that no longer holds the grant.
- Simultaneous new requests: VGA first, then round-robin order.
- Requests asserted during reset are evaluated on the first edge after reset deasserts.
- busy_o = |gnt_o.

Test Plan:
- Reset check: req_i = 0, resetn pulsed low mid-burst -> gnt_o = 0, rvalid_o = 0, SRAM_we_n = 1, SRAM_address = 0 immediately; in-flight rvalid suppressed.
- Single read: req_i = 4'b0010, addr_i[1] = 18'h00100, we_n = 1 held 3 cycles -> gnt_o = 4'b0010 one cycle after req; SRAM_address = 18'h00100; three rvalid_o[1] pulses, each 2 cycles after its access.
- Write path: M3 req with we_n = 0, wdata = 16'hABCD, addr = 18'h3F000 -> SRAM_we_n = 0 and SRAM_write_data = 16'hABCD while granted; no rvalid_o[2].
- Round-robin with burst limit: req_i = 4'b0111 held continuously -> grants 0,1,2,0 in order, each exactly 16 cycles long, no idle gaps.
- VGA preemption: M1 owning, mid-burst req_i[3] rises -> gnt_o = 4'b1000 next edge; VGA held 40 cycles past MAX_BURST; M1 regains grant one cycle after VGA drops req.
- Read tags across a handover: M1 reads in its last owned cycle, then the grant passes to UART -> rvalid_o[1] still pulses 2 cycles after that access; rvalid_o[0] stays 0 for UART writes.
